// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants for the instruction fetch stage.
package riscv_pkg;

    // Canonical NOP (addi x0, x0, 0) presented alongside a fetch trap.
    localparam logic [31:0] NOP_INST = 32'h00000013;

    // One decode-side entry: instruction word, its PC and the misaligned-fetch flag.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        trap;
    } fetch_entry_t;

    // Fetch control states.
    typedef enum logic {
        STATE_RUN  = 1'b0,
        STATE_TRAP = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fifo.sv
// Small synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
// Head entry is read straight from the storage registers (first-word fall-through).
module if_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [AW:0]  count,
    output logic         empty
);

    fetch_entry_t   entries [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           do_push;
    logic           do_pop;

    // Flush wins over both push and pop; popping an empty FIFO is a no-op.
    assign do_push = push && !flush;
    assign do_pop  = pop && !flush && (count_reg != '0);

    // Entry storage; cleared on reset so an empty FIFO presents all-zero fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (do_push) begin
            entries[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and count; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    assign head  = entries[rd_ptr_reg];
    assign count = count_reg;
    assign empty = (count_reg == '0);

    // The fetch credit scheme guarantees a word never arrives for a full buffer.
    push_never_full: assert property (@(posedge clk) disable iff (!rst_n)
        do_push |-> (count_reg != (AW+1)'(DEPTH)));

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC, issues word-aligned requests to a
// latency-variable in-order imem, buffers returned words and hands
// {inst, pc, trap} to decode. Redirects flush the buffer and drop stale responses.
// Optional feature macro: IF_STAGE_BYPASS_EN (same-cycle forwarding of a response
// into an empty buffer). Default build: every word goes through the FIFO.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h00000000,
    parameter int          DEPTH      = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_trap
);

    localparam int             CW          = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_LIMIT = (CW+1)'(DEPTH);

    fetch_state_t   state_reg;
    fetch_state_t   state_next;
    logic [31:0]    fetch_pc_reg;
    logic [31:0]    fetch_pc_next;
    logic [CW-1:0]  inflight_reg;
    logic [CW-1:0]  inflight_next;
    logic [CW-1:0]  drop_reg;
    logic [CW-1:0]  drop_next;
    logic           trap_pend_reg;
    logic           trap_pend_next;

    fetch_entry_t   fifo_head;
    fetch_entry_t   fifo_wdata;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty;
    logic           fifo_push;
    logic           fifo_pop;

    logic [CW:0]    occupancy;
    logic           req_fire;
    logic           rsp_live;
    logic           bypass;
    logic           inst_pop;
    logic           redirect_trap;
    logic [31:0]    rsp_pc;

    assign occupancy     = {1'b0, inflight_reg} + {1'b0, fifo_count};
    assign rsp_live      = i_imem_rsp_valid && (drop_reg == '0);
    assign redirect_trap = (i_redirect_pc[1:0] != 2'b00);

    // Responses are in order, so a live response belongs to the oldest outstanding
    // request, which sits inflight words behind the next fetch address.
    assign rsp_pc = fetch_pc_reg - 32'({inflight_reg, 2'b00});

    // Request while there is room for every outstanding word; gated by reset so
    // the port is quiet while the stage is held in reset.
    assign o_imem_req_valid = i_rst_n && (state_reg == STATE_RUN)
                              && (occupancy < DEPTH_LIMIT) && !i_redirect_valid;
    assign o_imem_req_addr  = {fetch_pc_reg[31:2], 2'b00};
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;

`ifdef IF_STAGE_BYPASS_EN
    assign bypass = fifo_empty && rsp_live && (state_reg == STATE_RUN);
`else
    assign bypass = 1'b0;
`endif

    // Decode-side presentation and next FSM state.
    always_comb begin
        state_next   = state_reg;
        o_inst_valid = 1'b0;
        o_inst       = fifo_head.inst;
        o_inst_pc    = fifo_head.pc;
        o_inst_trap  = 1'b0;
        case (state_reg)
            STATE_RUN: begin
                if (bypass) begin
                    o_inst_valid = 1'b1;
                    o_inst       = i_imem_rsp_data;
                    o_inst_pc    = rsp_pc;
                end else begin
                    o_inst_valid = !fifo_empty;
                    o_inst_trap  = fifo_head.trap;
                end
            end
            STATE_TRAP: begin
                o_inst_valid = trap_pend_reg;
                o_inst       = NOP_INST;
                o_inst_pc    = fetch_pc_reg;
                o_inst_trap  = trap_pend_reg;
            end
            default: begin
                state_next = STATE_RUN;
            end
        endcase
        if (i_redirect_valid) begin
            state_next = redirect_trap ? STATE_TRAP : STATE_RUN;
        end
    end

    // A pop coinciding with a redirect is discarded along with the rest of the stream.
    assign inst_pop   = o_inst_valid && i_inst_ready && !i_redirect_valid;
    assign fifo_pop   = inst_pop && (state_reg == STATE_RUN) && !bypass;
    assign fifo_push  = rsp_live && !i_redirect_valid && !(bypass && i_inst_ready);
    assign fifo_wdata = {i_imem_rsp_data, rsp_pc, 1'b0};

    // Request/response bookkeeping and redirect handling.
    always_comb begin
        inflight_next  = inflight_reg + CW'(req_fire) - CW'(i_imem_rsp_valid);
        drop_next      = drop_reg;
        fetch_pc_next  = fetch_pc_reg;
        trap_pend_next = trap_pend_reg;
        if (i_redirect_valid) begin
            drop_next      = inflight_next;
            fetch_pc_next  = i_redirect_pc;
            trap_pend_next = redirect_trap;
        end else begin
            if (i_imem_rsp_valid && (drop_reg != '0)) begin
                drop_next = drop_reg - 1'b1;
            end
            if (req_fire) begin
                fetch_pc_next = fetch_pc_reg + 32'd4;
            end
            if ((state_reg == STATE_TRAP) && inst_pop) begin
                trap_pend_next = 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= STATE_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Fetch PC, outstanding-request and stale-response counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc_reg  <= RESET_ADDR;
            inflight_reg  <= '0;
            drop_reg      <= '0;
            trap_pend_reg <= 1'b0;
        end else begin
            fetch_pc_reg  <= fetch_pc_next;
            inflight_reg  <= inflight_next;
            drop_reg      <= drop_next;
            trap_pend_reg <= trap_pend_next;
        end
    end

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .flush     (i_redirect_valid),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    // A response can only answer a request that is still outstanding.
    rsp_needs_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_imem_rsp_valid |-> (inflight_reg != '0));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: in-order imem model with random latency and
// backpressure, directed scenarios plus random redirect segments, and a
// scoreboard of expected decode-side entries consumed by a separate monitor.
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RST_ADDR = 32'h00000100;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_trap;

    if_stage #(
        .RESET_ADDR (RST_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_req_addr  (req_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_inst_valid     (inst_valid),
        .i_inst_ready     (inst_ready),
        .o_inst           (inst),
        .o_inst_pc        (inst_pc),
        .o_inst_trap      (inst_trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;
    int cyc;
    int pop_cnt;
    int acc_cnt;
    int acc_snap;
    int lat_min;
    int lat_max;
    int ready_pct;
    bit rand_ready;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t        pend_q[$];
    logic [31:0]  acc_log[$];
    logic [31:0]  rsp_addr;
    fetch_entry_t exp_q[$];
    fetch_entry_t mon_e;

    // Memory contents: one recognisable word at 0x400, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h00000400) return 32'h00A00093;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0033;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference instruction stream after a (re)start: sequential words from pc,
    // or a single trap entry for a misaligned target.
    task automatic load_stream(input logic [31:0] pc);
        fetch_entry_t e;
        exp_q.delete();
        if (pc[1:0] != 2'b00) begin
            e.inst = NOP_INST;
            e.pc   = pc;
            e.trap = 1'b1;
            exp_q.push_back(e);
        end else begin
            for (int i = 0; i < 64; i++) begin
                e.pc   = pc + 32'(4 * i);
                e.inst = mem_word(e.pc);
                e.trap = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            if (rand_ready) inst_ready = ($urandom_range(0, 3) != 0);
            step();
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        load_stream(pc);
        acc_log.delete();
        acc_snap = acc_cnt;
        step();
        redirect_valid = 1'b0;
    endtask

    // Memory response side: in-order responses once due, random request backpressure.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_addr  = pend_q[0].addr;
            rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            rsp_valid = 1'b0;
            rsp_addr  = 32'hFFFF_FFFF;
            rsp_data  = $urandom;
        end
        req_ready = ($urandom_range(0, 99) < ready_pct);
    end

    // Memory request side: record accepted requests, check address alignment
    // and that a stalled request is held until accepted.
    logic        prev_req_stall;
    logic [31:0] prev_req_addr;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_req_stall && !redirect_valid) begin
                check32("req_held_valid", req_valid, 1);
                check32("req_held_addr", req_addr, prev_req_addr);
            end
            if (req_valid) check32("req_addr_aligned", req_addr[1:0], 0);
            if (req_valid && req_ready) begin
                pend_q.push_back('{addr: req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
                acc_log.push_back(req_addr);
                acc_cnt++;
            end
            prev_req_stall = req_valid && !req_ready;
            prev_req_addr  = req_addr;
        end else begin
            prev_req_stall = 1'b0;
        end
    end

    // Monitor: every consumed entry is compared with the scoreboard head.
    logic        prev_out_stall;
    logic [31:0] prev_inst;
    logic [31:0] prev_pc;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_out_stall) begin
                check32("inst_hold_valid", inst_valid, 1);
                check32("inst_hold_word", inst, prev_inst);
                check32("inst_hold_pc", inst_pc, prev_pc);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_inst: got pc %h inst %h trap %b, required no entry", inst_pc, inst, inst_trap);
                end else begin
                    mon_e = exp_q.pop_front();
                    check32("inst_pc", inst_pc, mon_e.pc);
                    check32("inst_word", inst, mon_e.inst);
                    check32("inst_trap", inst_trap, mon_e.trap);
                end
                pop_cnt++;
            end
            prev_out_stall = inst_valid && !inst_ready && !redirect_valid;
            prev_inst      = inst;
            prev_pc        = inst_pc;
        end else begin
            prev_out_stall = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int snap;
        bit found;
        logic [31:0] tgt;
        rst_n = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data = '0;
        rsp_addr = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_ready = 1'b0;
        rand_ready = 1'b0;
        ready_pct = 100;
        lat_min = 1;
        lat_max = 1;
        load_stream(RST_ADDR);

        // Reset state
        repeat (3) @(negedge clk);
        check32("rst_req_valid", req_valid, 0);
        check32("rst_req_addr", req_addr, RST_ADDR);
        check32("rst_inst_valid", inst_valid, 0);
        check32("rst_inst", inst, 0);
        check32("rst_inst_pc", inst_pc, 0);
        check32("rst_inst_trap", inst_trap, 0);

        // First word latency after reset release
        step();
        rst_n = 1'b1;
        inst_ready = 1'b1;
        first = 99;
        for (int e = 0; e < 8; e++) begin
            @(negedge clk);
            #1;
            if (inst_valid) begin
                first = e;
                break;
            end
        end
`ifdef IF_STAGE_BYPASS_EN
        check32("first_valid_latency", first, 1);
`else
        check32("first_valid_latency", first, 2);
`endif
        step();
        run(6);
        check32("reset_req0", acc_log.size() > 0 ? acc_log[0] : 32'hDEADBEEF, 32'h100);
        check32("reset_req1", acc_log.size() > 1 ? acc_log[1] : 32'hDEADBEEF, 32'h104);
        check32("reset_req2", acc_log.size() > 2 ? acc_log[2] : 32'hDEADBEEF, 32'h108);

        // Decode stalled: credit limits accepted requests to DEPTH, then drain
        inst_ready = 1'b0;
        redirect(32'h00000500);
        run(15);
        @(negedge clk);
        #1;
        check32("stall_accepts", acc_cnt - acc_snap, DEPTH);
        check32("stall_req_valid", req_valid, 0);
        step();
        snap = pop_cnt;
        inst_ready = 1'b1;
        run(10);
        check32("drain_progress", (pop_cnt - snap) >= 4, 1);

        // Two requests in flight, then redirect: late responses must be dropped
        lat_min = 3;
        lat_max = 3;
        redirect(32'h00000180);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (pend_q.size() >= 2) begin
                found = 1'b1;
                break;
            end
        end
        check32("two_inflight_reached", found, 1);
        @(posedge clk);
        #1;
        snap = pop_cnt;
        redirect(32'h00000200);
        run(15);
        check32("redirect_progress", (pop_cnt - snap) >= 2, 1);

        // Misaligned target: one trap entry, no requests, until redirected away
        lat_min = 1;
        lat_max = 1;
        redirect(32'h00000202);
        run(10);
        check32("trap_no_requests", acc_cnt - acc_snap, 0);
        check32("trap_entry_consumed", exp_q.size(), 0);
        snap = pop_cnt;
        redirect(32'h00000300);
        run(10);
        check32("trap_exit_progress", (pop_cnt - snap) >= 3, 1);

        // Address wrap at the top of the address space
        redirect(32'hFFFFFFF8);
        run(8);
        check32("wrap_addr_fc", acc_log.size() > 1 ? acc_log[1] : 32'hDEADBEEF, 32'hFFFFFFFC);
        check32("wrap_addr_0", acc_log.size() > 2 ? acc_log[2] : 32'hDEADBEEF, 32'h00000000);

        // Response-to-decode latency into an empty buffer
        lat_min = 2;
        lat_max = 2;
        redirect(32'h00000400);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_addr == 32'h00000400) begin
                found = 1'b1;
                break;
            end
        end
        check32("lat_rsp_seen", found, 1);
`ifdef IF_STAGE_BYPASS_EN
        check32("bypass_same_cycle_valid", inst_valid, 1);
        check32("bypass_same_cycle_inst", inst, 32'h00A00093);
`else
        check32("nobypass_cycle_n_valid", inst_valid, 0);
        @(negedge clk);
        #1;
        check32("nobypass_cycle_n1_valid", inst_valid, 1);
        check32("nobypass_cycle_n1_inst", inst, 32'h00A00093);
        check32("nobypass_cycle_n1_pc", inst_pc, 32'h00000400);
`endif
        step();
        run(4);

        // Random segments: random latency, backpressure, decode stalls, targets
        rand_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            lat_min = 1;
            lat_max = $urandom_range(1, 3);
            ready_pct = $urandom_range(50, 100);
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                if (tgt[1:0] == 2'b00) tgt[1:0] = 2'b10;
            end else begin
                tgt[1:0] = 2'b00;
            end
            redirect(tgt);
            run($urandom_range(10, 40));
        end

        rand_ready = 1'b0;
        inst_ready = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
